cell_select_decoder: RTL and testbench

CELL_SELECT_DECODER -- requirements
Module: cell_select_decoder

---
 rtl/cell_select_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_cell_select_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_select_decoder.sv
// Tic-tac-toe cell selector: maps the cursor to a board cell, turns the raw button into press events and runs the game.
// Define CELL_WIN_DETECT_EN to enable line (win) detection; without it only a full board ends the game, as a draw.
module cell_select_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic       place_btn,
    input  logic       new_game,
    output logic [3:0] cell_idx,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic       turn,
    output logic       reject,
    output logic [1:0] winner
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned CELL_W  = 4;
    localparam int unsigned NCELL   = 9;

    localparam logic [COORD_W-1:0] COL0_LO  = COORD_W'(163);
    localparam logic [COORD_W-1:0] COL1_LO  = COORD_W'(268);
    localparam logic [COORD_W-1:0] COL2_LO  = COORD_W'(373);
    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(477);
    localparam logic [COORD_W-1:0] ROW0_LO  = COORD_W'(83);
    localparam logic [COORD_W-1:0] ROW1_LO  = COORD_W'(188);
    localparam logic [COORD_W-1:0] ROW2_LO  = COORD_W'(293);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(397);

    localparam logic [CELL_W-1:0] OFF_BOARD = CELL_W'(15);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CELL_W-1:0]   target;
    logic [CELL_W-1:0]   target_nxt;
    logic [NCELL-1:0]    board_x_nxt;
    logic [NCELL-1:0]    board_o_nxt;
    logic                turn_nxt;
    logic                reject_nxt;
    logic [1:0]          winner_nxt;

    logic [1:0]          col_c;
    logic [1:0]          row_c;
    logic                col_ok_c;
    logic                row_ok_c;
    logic [CELL_W-1:0]   cell_c;

    logic                btn_meta;
    logic                btn_sync;
    logic                btn_prev;
    logic                press_c;

    logic [NCELL-1:0]    cur_mask_c;
    logic [NCELL-1:0]    tgt_mask_c;
    logic                occupied_c;
    logic                full_c;
    logic                x_line_c;
    logic                o_line_c;

    // Cursor position to column/row bands
    always_comb begin
        col_c    = 2'd0;
        col_ok_c = 1'b1;
        if (x_pos >= COL0_LO && x_pos < COL1_LO) begin
            col_c = 2'd0;
        end else if (x_pos >= COL1_LO && x_pos < COL2_LO) begin
            col_c = 2'd1;
        end else if (x_pos >= COL2_LO && x_pos <= COL_LAST) begin
            col_c = 2'd2;
        end else begin
            col_ok_c = 1'b0;
        end

        row_c    = 2'd0;
        row_ok_c = 1'b1;
        if (y_pos >= ROW0_LO && y_pos < ROW1_LO) begin
            row_c = 2'd0;
        end else if (y_pos >= ROW1_LO && y_pos < ROW2_LO) begin
            row_c = 2'd1;
        end else if (y_pos >= ROW2_LO && y_pos <= ROW_LAST) begin
            row_c = 2'd2;
        end else begin
            row_ok_c = 1'b0;
        end

        if (col_ok_c && row_ok_c) begin
            cell_c = ({2'b00, row_c} << 1) + {2'b00, row_c} + {2'b00, col_c};
        end else begin
            cell_c = OFF_BOARD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_idx <= OFF_BOARD;
        end else begin
            cell_idx <= cell_c;
        end
    end

    // Two-flop synchronizer plus edge flop; a held button produces a single event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_meta <= place_btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign press_c    = btn_sync & ~btn_prev;
    assign cur_mask_c = NCELL'(1) << cell_idx;
    assign tgt_mask_c = NCELL'(1) << target;
    assign occupied_c = |(cur_mask_c & (board_x | board_o));
    assign full_c     = &(board_x | board_o);

`ifdef CELL_WIN_DETECT_EN
    function automatic logic has_line(input logic [NCELL-1:0] b);
        has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8])
                 | (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8])
                 | (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    assign x_line_c = has_line(board_x);
    assign o_line_c = has_line(board_o);
`else
    assign x_line_c = 1'b0;
    assign o_line_c = 1'b0;
`endif

    // State and game registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            target  <= '0;
            board_x <= '0;
            board_o <= '0;
            turn    <= 1'b0;
            reject  <= 1'b0;
            winner  <= WIN_NONE;
        end else begin
            state   <= state_nxt;
            target  <= target_nxt;
            board_x <= board_x_nxt;
            board_o <= board_o_nxt;
            turn    <= turn_nxt;
            reject  <= reject_nxt;
            winner  <= winner_nxt;
        end
    end

    // Next-state and game update; new_game overrides everything, including a coincident press
    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        board_x_nxt = board_x;
        board_o_nxt = board_o;
        turn_nxt    = turn;
        reject_nxt  = 1'b0;
        winner_nxt  = winner;

        if (new_game) begin
            state_nxt   = IDLE;
            board_x_nxt = '0;
            board_o_nxt = '0;
            turn_nxt    = 1'b0;
            winner_nxt  = WIN_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (press_c) begin
                        if (cell_idx != OFF_BOARD && !occupied_c) begin
                            target_nxt = cell_idx;
                            state_nxt  = PLACE;
                        end else begin
                            reject_nxt = 1'b1;
                        end
                    end
                end
                PLACE: begin
                    if (!turn) begin
                        board_x_nxt = board_x | tgt_mask_c;
                    end else begin
                        board_o_nxt = board_o | tgt_mask_c;
                    end
                    turn_nxt  = ~turn;
                    state_nxt = CHECK;
                end
                CHECK: begin
                    if (x_line_c) begin
                        winner_nxt = WIN_X;
                        state_nxt  = DONE;
                    end else if (o_line_c) begin
                        winner_nxt = WIN_O;
                        state_nxt  = DONE;
                    end else if (full_c) begin
                        winner_nxt = WIN_DRAW;
                        state_nxt  = DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_select_decoder.sv
// Scoreboard bench for cell_select_decoder; expected board state comes from a behavioural game model.
`timescale 1ns/1ps
module tb_cell_select_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       place_btn;
    logic       new_game;
    logic [3:0] cell_idx;
    logic [8:0] board_x;
    logic [8:0] board_o;
    logic       turn;
    logic       reject;
    logic [1:0] winner;

    cell_select_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .place_btn (place_btn),
        .new_game  (new_game),
        .cell_idx  (cell_idx),
        .board_x   (board_x),
        .board_o   (board_o),
        .turn      (turn),
        .reject    (reject),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] bx;
        logic [8:0] bo;
        logic       trn;
        logic [1:0] win;
        int         rej;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    logic [8:0] m_bx;
    logic [8:0] m_bo;
    logic       m_turn;
    logic [1:0] m_win;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_cell(input int x, input int y);
        int c, r;
        if (x < 163 || x > 477 || y < 83 || y > 397) return 15;
        c = (x - 163) / 105;
        r = (y - 83) / 105;
        return r * 3 + c;
    endfunction

    function automatic logic model_line(input logic [8:0] b);
        int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int i = 0; i < 8; i++)
            if (b[lines[i][0]] && b[lines[i][1]] && b[lines[i][2]]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_bx = '0; m_bo = '0; m_turn = 1'b0; m_win = 2'b00;
    endtask

    function automatic exp_t model_snapshot(input int rej);
        exp_t e;
        e.bx = m_bx; e.bo = m_bo; e.trn = m_turn; e.win = m_win; e.rej = rej;
        return e;
    endfunction

    task automatic model_press(input int x, input int y);
        int   c;
        int   rej;
        logic xl;
        logic ol;
        c = model_cell(x, y);
        rej = 0;
        xl = 1'b0;
        ol = 1'b0;
        if (m_win == 2'b00) begin
            if (c == 15) begin
                rej = 1;
            end else if (m_bx[c] || m_bo[c]) begin
                rej = 1;
            end else begin
                if (!m_turn) m_bx[c] = 1'b1;
                else         m_bo[c] = 1'b1;
                m_turn = !m_turn;
`ifdef CELL_WIN_DETECT_EN
                xl = model_line(m_bx);
                ol = model_line(m_bo);
`endif
                if (xl)                          m_win = 2'b01;
                else if (ol)                     m_win = 2'b10;
                else if ((m_bx | m_bo) == 9'h1FF) m_win = 2'b11;
            end
        end
        sb.push_back(model_snapshot(rej));
    endtask

    task automatic compare_out(input logic [8:0] bx, input logic [8:0] bo, input logic trn,
                               input logic [1:0] win, input int rej);
        exp_t e;
        e = sb.pop_front();
        check("board_x", bx, e.bx);
        check("board_o", bo, e.bo);
        check("turn", trn, e.trn);
        check("winner", win, e.win);
        check("reject_cycles", rej, e.rej);
    endtask

    // One press: board sampled after edge k+3, winner after k+4
    task automatic press_at(input int x, input int y);
        int rej; logic [8:0] bx, bo; logic trn; logic [1:0] win;
        rej = 0; bx = '0; bo = '0; trn = 1'b0; win = 2'b00;
        @(negedge clk);
        x_pos = 10'(x); y_pos = 10'(y); place_btn = 1'b1;
        model_press(x, y);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (reject === 1'b1) rej++;
            if (i == 4) begin bx = board_x; bo = board_o; trn = turn; place_btn = 1'b0; end
            if (i == 5) win = winner;
        end
        compare_out(bx, bo, trn, win, rej);
        repeat (2) @(negedge clk);
    endtask

    task automatic press_cell(input int n);
        press_at(215 + 105 * (n % 3), 135 + 105 * (n / 3));
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        model_clear();
        sb.push_back(model_snapshot(0));
        @(negedge clk);
        new_game = 1'b0;
        compare_out(board_x, board_o, turn, winner, (reject === 1'b1) ? 1 : 0);
    endtask

    // Press event and new_game land on the same edge: the clear wins
    task automatic press_with_new_game();
        int rej; logic [8:0] bx, bo; logic trn; logic [1:0] win;
        rej = 0; bx = '0; bo = '0; trn = 1'b0; win = 2'b00;
        @(negedge clk);
        x_pos = 10'd215; y_pos = 10'd135; place_btn = 1'b1;
        model_clear();
        sb.push_back(model_snapshot(0));
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (reject === 1'b1) rej++;
            if (i == 2) new_game = 1'b1;
            if (i == 3) new_game = 1'b0;
            if (i == 4) begin bx = board_x; bo = board_o; trn = turn; place_btn = 1'b0; end
            if (i == 5) win = winner;
        end
        compare_out(bx, bo, trn, win, rej);
        repeat (2) @(negedge clk);
    endtask

    // Reset while in PLACE aborts the placement; the still-held button then places once
    task automatic reset_mid_place();
        int rej; logic [8:0] bx, bo; logic trn; logic [1:0] win;
        rej = 0; bx = '0; bo = '0; trn = 1'b0; win = 2'b00;
        @(negedge clk);
        x_pos = 10'd320; y_pos = 10'd240; place_btn = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_board_x", board_x, 9'h000);
        check("rst_board_o", board_o, 9'h000);
        check("rst_turn", turn, 1'b0);
        check("rst_cell_idx", cell_idx, 4'd15);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        model_press(320, 240);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (reject === 1'b1) rej++;
            if (i == 4) begin bx = board_x; bo = board_o; trn = turn; end
            if (i == 5) win = winner;
        end
        place_btn = 1'b0;
        compare_out(bx, bo, trn, win, rej);
        repeat (4) @(negedge clk);
        check("held_once_board_x", board_x, m_bx);
        check("held_once_turn", turn, m_turn);
    endtask

    int tx [12] = '{320, 100, 163, 162, 267, 268, 477, 478, 372, 373, 200, 300};
    int ty [12] = '{240, 240,  83,  83, 187, 188, 397, 397, 292, 100, 300, 398};
    int tc [12] = '{  4,  15,   0,  15,   0,   4,   8,  15,   4,   2,   6,  15};
    int win_seq  [6] = '{0, 3, 1, 4, 2, 8};
    int draw_seq [10] = '{0, 1, 2, 4, 3, 5, 7, 6, 8, 0};

    initial begin
        rst = 1'b1; place_btn = 1'b0; new_game = 1'b0; x_pos = '0; y_pos = '0;
        model_clear();
        #2;
        check("reset_cell_idx", cell_idx, 4'd15);
        check("reset_board_x", board_x, 9'h000);
        check("reset_board_o", board_o, 9'h000);
        check("reset_turn", turn, 1'b0);
        check("reset_reject", reject, 1'b0);
        check("reset_winner", winner, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            x_pos = 10'(tx[i]); y_pos = 10'(ty[i]);
            @(negedge clk);
            check($sformatf("cell_idx(%0d,%0d)", tx[i], ty[i]), cell_idx, tc[i]);
        end

        press_cell(4);
        press_cell(4);
        press_at(500, 240);
        press_with_new_game();

        for (int i = 0; i < 6; i++) press_cell(win_seq[i]);

        pulse_new_game();
        for (int i = 0; i < 10; i++) press_cell(draw_seq[i]);

        pulse_new_game();
        press_cell(0);
        press_cell(1);
        reset_mid_place();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
